// File: rtl/sd_slv_pkg.sv
// Shared types and constants for the SD slave read-block sequencer.
// State encoding, CRC16 polynomial and DAT bus width.
package sd_slv_pkg;

  localparam int unsigned DAT_W      = 4;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StStart = 3'd2,
    StData  = 3'd3,
    StCrc   = 3'd4,
    StTail  = 3'd5,
    StStop  = 3'd6,
    StGap   = 3'd7
  } state_e;

endpackage

// File: rtl/sd_slv_crc16.sv
// One-bit serial CRC16 (x^16+x^12+x^5+1) for a single DAT line.
// clr has priority over en (data update), which has priority over shift (readout).
module sd_slv_crc16
  import sd_slv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  input  logic shift,
  output logic msb
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((din ^ crc_q[15]) ? CRC16_POLY : 16'h0000);
    end else if (shift) begin
      crc_d = {crc_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign msb = crc_q[15];

endmodule

// File: rtl/sd_slv_rd_seq.sv
// SD slave read-block sequencer: fetches a block from sync ROM, emits start/data/CRC/stop strobes.
// Optional multi-block streaming with stop_req is enabled by defining SD_SLV_RD_MULTI_EN.
module sd_slv_rd_seq
  import sd_slv_pkg::*;
#(
  parameter int unsigned BLK_NIB = 1024,
  parameter int unsigned AW      = 10,
  parameter int unsigned NAC_CYC = 2,
  parameter int unsigned BLK_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_req,
  input  logic [AW-1:0]    base_addr,
  input  logic [DAT_W-1:0] rom_din,
  output logic             rom_en,
  output logic [AW-1:0]    rom_addr,
  output logic             read,
  output logic             cen_rom,
  output logic             cen,
  output logic [DAT_W-1:0] crc,
  output logic             stop_en,
  output logic             ei,
  output logic             busy,
  output logic             blk_done
);

  localparam int unsigned CNT_W = ($clog2(BLK_NIB) > 4) ? $clog2(BLK_NIB) : 4;

  localparam logic [CNT_W-1:0] DataLast = CNT_W'(BLK_NIB - 1);
  localparam logic [CNT_W-1:0] CrcLast  = CNT_W'(15);
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(NAC_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;

`ifdef SD_SLV_RD_MULTI_EN
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(BLK_GAP - 1);
  logic stop_q, stop_d, stop_hit;
  assign stop_hit = stop_q | stop_req;
`else
  logic unused_stop_req;
  assign unused_stop_req = stop_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWait;
          cnt_d   = '0;
          addr_d  = base_addr;
        end
      end
      StWait: begin
`ifdef SD_SLV_RD_MULTI_EN
        if (stop_hit) begin
          state_d = StIdle;
        end else
`endif
        if (cnt_q == WaitLast) begin
          state_d = StStart;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: begin
        if (cnt_q == DataLast) begin
          state_d = StCrc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCrc: begin
        if (cnt_q == CrcLast) begin
          state_d = StTail;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // TAIL keeps stop_en clear of the last CRC nibble still leaving the mux register.
      StTail: state_d = StStop;
      StStop: begin
`ifdef SD_SLV_RD_MULTI_EN
        state_d = stop_hit ? StIdle : StGap;
        cnt_d   = '0;
`else
        state_d = StIdle;
`endif
      end
`ifdef SD_SLV_RD_MULTI_EN
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StStart;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    // Address advances on every ROM fetch so consecutive blocks stay contiguous.
    if (rom_en) begin
      addr_d = addr_q + 1'b1;
    end
  end

`ifdef SD_SLV_RD_MULTI_EN
  always_comb begin
    stop_d = (state_d == StIdle) ? 1'b0 : (stop_q | (busy & stop_req));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
    end
  end
`endif

  always_comb begin
    rom_en   = (state_q == StStart) || ((state_q == StData) && (cnt_q != DataLast));
    read     = (state_q == StStart);
    cen_rom  = (state_q == StData);
    cen      = (state_q == StCrc);
    stop_en  = (state_q == StStop);
    blk_done = (state_q == StStop);
    ei       = (state_q == StData) || (state_q == StCrc) ||
               (state_q == StTail) || (state_q == StStop);
    busy     = (state_q != StIdle);
  end

  assign rom_addr = addr_q;

  for (genvar i = 0; i < DAT_W; i++) begin : g_crc
    sd_slv_crc16 u_crc (
      .clk   (clk),
      .rst   (rst),
      .clr   (read),
      .en    (cen_rom),
      .din   (rom_din[i]),
      .shift (cen),
      .msb   (crc[i])
    );
  end

endmodule

// File: tb/tb_sd_slv_rd_seq.sv
// Self-checking bench for sd_slv_rd_seq: frame-offset reference model plus directed scenarios.
// Multi-block expectations follow SD_SLV_RD_MULTI_EN.
module tb_sd_slv_rd_seq;

  localparam int N   = 1024;
  localparam int AW  = 10;
  localparam int NAC = 2;
  localparam int GAP = 2;
  localparam int P   = N + 19 + GAP;  // START-to-START period in multi-block mode
`ifdef SD_SLV_RD_MULTI_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop_req;
  logic [AW-1:0] base_addr;
  logic [3:0]    rom_din = 4'h0;
  logic          rom_en, read, cen_rom, cen, stop_en, ei, busy, blk_done;
  logic [AW-1:0] rom_addr;
  logic [3:0]    crc;

  always #5 clk = ~clk;

  sd_slv_rd_seq #(
    .BLK_NIB (N),
    .AW      (AW),
    .NAC_CYC (NAC),
    .BLK_GAP (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop_req  (stop_req),
    .base_addr (base_addr),
    .rom_din   (rom_din),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .read      (read),
    .cen_rom   (cen_rom),
    .cen       (cen),
    .crc       (crc),
    .stop_en   (stop_en),
    .ei        (ei),
    .busy      (busy),
    .blk_done  (blk_done)
  );

  logic [3:0] rom_mem [0:N-1];
  always @(posedge clk) if (rom_en) rom_din <= rom_mem[rom_addr];

  int compared = 0, mismatched = 0, cyc = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] blk_crc(input logic [AW-1:0] a0, input int line);
    logic [15:0]   c;
    logic [AW-1:0] a;
    logic [3:0]    nib;
    c = '0;
    for (int j = 0; j < N; j++) begin
      a   = a0 + AW'(j);
      nib = rom_mem[a];
      c   = crc_step(c, nib[line]);
    end
    return c;
  endfunction

  // Reference model: a frame is described only by the cycle offset since start acceptance.
  bit            m_act = 1'b0, m_stop = 1'b0;
  int            m_t = 0, m_r;
  logic [AW-1:0] m_base;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act  = 1'b0;
      m_stop = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act  = 1'b1;
        m_t    = 1;
        m_base = base_addr;
        m_stop = 1'b0;
      end
    end else begin
      if (MULTI && stop_req) m_stop = 1'b1;
      if (m_t <= NAC) begin
        if (MULTI && m_stop) m_act = 1'b0;
        else m_t++;
      end else begin
        m_r = (m_t - NAC - 1) % P;
        if (m_r == N + 18 && (!MULTI || m_stop)) m_act = 1'b0;
        else m_t++;
      end
    end
  end

  logic [15:0]   crc_exp [4];
  logic          e_rom_en, e_read, e_cen_rom, e_cen, e_stop, e_ei;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_crc;
  int            o, k, r, j;
  int            read_cyc, stop_cyc, n_cen_rom, n_cen, n_blk, first_cen_rom, last_cen_rom;

  always @(negedge clk) begin
    if (cmp_on) begin
      {e_rom_en, e_read, e_cen_rom, e_cen, e_stop, e_ei} = '0;
      e_addr = '0;
      e_crc  = '0;
      r      = -1;
      if (m_act && m_t > NAC) begin
        o         = m_t - NAC - 1;
        k         = o / P;
        r         = o % P;
        e_rom_en  = (r < N);
        e_addr    = m_base + AW'(k * N + r);
        e_read    = (r == 0);
        e_cen_rom = (r >= 1 && r <= N);
        e_cen     = (r > N && r <= N + 16);
        e_stop    = (r == N + 18);
        e_ei      = (r >= 1 && r <= N + 18);
        if (r == 0)
          for (int l = 0; l < 4; l++) crc_exp[l] = blk_crc(m_base + AW'(k * N), l);
        if (e_cen) begin
          j = r - N - 1;
          for (int l = 0; l < 4; l++) e_crc[l] = crc_exp[l][15-j];
        end
      end
      chk("busy", busy, m_act);
      chk("read", read, e_read);
      chk("rom_en", rom_en, e_rom_en);
      chk("cen_rom", cen_rom, e_cen_rom);
      chk("cen", cen, e_cen);
      chk("stop_en", stop_en, e_stop);
      chk("blk_done", blk_done, e_stop);
      chk("ei", ei, e_ei);
      if (e_rom_en) chk("rom_addr", rom_addr, e_addr);
      if (e_cen) chk("crc", crc, e_crc);
      if (read) read_cyc = cyc;
      if (stop_en) stop_cyc = cyc;
      if (cen_rom) begin
        if (n_cen_rom == 0) first_cen_rom = cyc;
        last_cen_rom = cyc;
        n_cen_rom++;
      end
      if (cen) n_cen++;
      if (blk_done) n_blk++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s0;
  task automatic clr_stats();
    read_cyc = -1; stop_cyc = -1; n_cen_rom = 0; n_cen = 0; n_blk = 0;
    first_cen_rom = -1; last_cen_rom = -1;
  endtask

  // s0 is the cycle in which start is sampled, so cycle ck of the frame is s0+k.
  task automatic do_start(input logic [AW-1:0] b);
    clr_stats();
    base_addr = b;
    start     = 1'b1;
    s0        = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] msg [9];
    logic [15:0] c;
    rst = 1'b1; start = 1'b0; stop_req = 1'b0; base_addr = '0;
    for (int i = 0; i < N; i++) rom_mem[i] = 4'h0;
    tick();
    tick();
    cmp_on = 1'b1;
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_crc", crc, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Pin the model's CRC against the CRC-16/XMODEM check value of "123456789".
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    c = '0;
    for (int i = 0; i < 9; i++)
      for (int b = 7; b >= 0; b--) c = crc_step(c, msg[i][b]);
    chk("model_crc_check", c, 16'h31c3);
    chk("model_crc_zero", blk_crc('0, 0), 16'h0000);

    // 1: all-zero ROM, base 0
    do_start(10'd0);
    run_until_idle(1200, "t1_idle");
    chk("t1_read_cyc", read_cyc - s0, 3);
    chk("t1_first_cen_rom", first_cen_rom - s0, 4);
    chk("t1_last_cen_rom", last_cen_rom - s0, 1027);
    chk("t1_n_cen_rom", n_cen_rom, 1024);
    chk("t1_n_cen", n_cen, 16);
    chk("t1_stop_cyc", stop_cyc - s0, 1045);
    chk("t1_n_blk", n_blk, 1);
    repeat (3) tick();

    // 2: all-F ROM
    for (int i = 0; i < N; i++) rom_mem[i] = 4'hf;
    do_start(10'd0);
    run_until_idle(1200, "t2_idle");
    chk("t2_n_blk", n_blk, 1);
    repeat (3) tick();

    // 3: wrap-around from 0x3fc
    for (int i = 0; i < N; i++) rom_mem[i] = 4'(i * 5 + 3);
    do_start(10'h3fc);
    run_until_idle(1200, "t3_idle");
    chk("t3_stop_cyc", stop_cyc - s0, 1045);
    repeat (3) tick();

    // 4: start pulses during DATA and CRC are ignored
    do_start(10'd17);
    repeat (199) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (828) tick();
    chk("t4_in_crc", cen, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    run_until_idle(1200, "t4_idle");
    repeat (8) tick();
    chk("t4_n_blk", n_blk, 1);
    chk("t4_busy_after", busy, 0);

    // 5: reset at DATA cycle 100, then a fresh frame
    do_start(10'd40);
    repeat (102) tick();
    chk("t5_in_data", cen_rom, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ei", ei, 0);
    chk("t5_rst_rom_addr", rom_addr, 0);
    tick();
    do_start(10'd300);
    run_until_idle(1200, "t5_idle");
    chk("t5_n_blk", n_blk, 1);
    repeat (3) tick();

    // 6: multi-block with stop_req in block 3 DATA
    for (int i = 0; i < N; i++) rom_mem[i] = 4'(i ^ (i >> 4));
    do_start(10'd5);
    repeat (2199) tick();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    run_until_idle(4000, "t6_idle");
    chk("t6_n_blk", n_blk, MULTI ? 3 : 1);
    repeat (3) tick();

`ifdef SD_SLV_RD_MULTI_EN
    // stop_req during WAIT aborts without strobes
    do_start(10'd9);
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    chk("t7_busy", busy, 0);
    repeat (6) tick();
    chk("t7_no_read", read_cyc, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
